// File: rtl/booth_mult_seq.sv
// booth_mult_seq: sequential signed WIDTHxWIDTH multiplier, radix-2 Booth,
// one recoding step per clock (WIDTH steps per product).
// Ports:
//   clk, reset      - clock, asynchronous active-high reset
//   start, a, b     - request pulse and signed operands (sampled in IDLE only)
//   busy, done      - busy in RUN/DONE; done is a one-cycle completion pulse
//   hi, lo          - upper/lower halves of the 2*WIDTH signed product
//   overflow        - product does not fit in WIDTH signed bits
module booth_mult_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             overflow
);

  localparam int unsigned AW = WIDTH + 1;
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    m_q, m_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             qm1_q, qm1_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [AW-1:0]    acc_sum;
  logic [AW-1:0]    acc_sh;
  logic [WIDTH-1:0] q_sh;

  // State register and datapath flops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      count_q <= count_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state, Booth step and result capture
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    acc_d   = acc_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    count_d = count_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    ovf_d   = ovf_q;

    // Booth recoding on {Q[0], q_m1}: 01 adds M, 10 subtracts M
    acc_sum = acc_q;
    case ({q_q[0], qm1_q})
      2'b01:   acc_sum = acc_q + m_q;
      2'b10:   acc_sum = acc_q - m_q;
      default: acc_sum = acc_q;
    endcase

    // Arithmetic right shift of {acc, Q, q_m1}
    acc_sh = {acc_sum[AW-1], acc_sum[AW-1:1]};
    q_sh   = {acc_sum[0], q_q[WIDTH-1:1]};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          m_d     = {a[WIDTH-1], a};
          q_d     = b;
          qm1_d   = 1'b0;
          acc_d   = '0;
          count_d = CW'(WIDTH);
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d   = acc_sh;
        q_d     = q_sh;
        qm1_d   = q_q[0];
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          hi_d    = acc_sh[WIDTH-1:0];
          lo_d    = q_sh;
          ovf_d   = (acc_sh[WIDTH-1:0] != {WIDTH{q_sh[WIDTH-1]}});
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status flops track the state being entered
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// tb_booth_mult_seq: scoreboard bench for booth_mult_seq (WIDTH=32).
module tb_booth_mult_seq;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        ovf;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        overflow;

  int          n_checks;
  int          n_fail;
  int          cyc_cnt;
  int          start_cyc;
  exp_t        sb[$];

  booth_mult_seq #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a_i),
    .b        (b_i),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] p;
    exp_t e;
    p     = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
    e.hi  = p[63:32];
    e.lo  = p[31:0];
    e.ovf = (p[63:32] != {32{p[31]}});
    return e;
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding request
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_done", 64'(done), 64'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("hi", 64'(hi), 64'(e.hi));
        check("lo", 64'(lo), 64'(e.lo));
        check("overflow", 64'(overflow), 64'(e.ovf));
      end
    end
  end

  task automatic start_op(input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    a_i   = x;
    b_i   = y;
    start = 1'b1;
    sb.push_back(model(x, y));
    @(posedge clk);
    #1;
    start_cyc = cyc_cnt;
    start     = 1'b0;
    a_i       = $urandom;
    b_i       = $urandom;
    check("busy_after_start", 64'(busy), 64'(1));
  endtask

  task automatic wait_done();
    int guard;
    guard = 0;
    while (done !== 1'b1 && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 200) check("done_timeout", 64'(0), 64'(1));
    else check("latency", 64'(cyc_cnt - start_cyc), 64'(32));
  endtask

  task automatic check_after();
    @(posedge clk);
    #1;
    check("done_one_cycle", 64'(done), 64'(0));
    check("busy_idle", 64'(busy), 64'(0));
  endtask

  task automatic run(input logic [31:0] x, input logic [31:0] y);
    start_op(x, y);
    wait_done();
    check_after();
  endtask

  initial begin
    logic [31:0] prev_lo;
    logic [31:0] prev_hi;
    logic [31:0] va [4];
    logic [31:0] vb [4];
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    start    = 1'b0;
    a_i      = '0;
    b_i      = '0;
    #12;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_hi", 64'(hi), 64'(0));
    check("rst_lo", 64'(lo), 64'(0));
    check("rst_ovf", 64'(overflow), 64'(0));
    @(negedge clk);
    reset = 1'b0;

    // Directed corner operands
    run(32'd3, 32'd5);
    check("3x5_lo_const", 64'(lo), 64'h0000_000F);
    va = '{32'hFFFF_FFF9, 32'h8000_0000, 32'h0001_0000, 32'h7FFF_FFFF};
    vb = '{32'd6,         32'h8000_0000, 32'h0001_0000, 32'hFFFF_FFFF};
    for (int i = 0; i < 4; i++) run(va[i], vb[i]);
    check("max_x_m1_lo_const", 64'(lo), 64'h8000_0001);
    for (int i = 0; i < 6; i++) run($urandom, $urandom);

    // start during RUN is ignored; outputs hold during RUN
    prev_lo = lo;
    prev_hi = hi;
    start_op(32'd3, 32'd5);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    check("hold_lo", 64'(lo), 64'(prev_lo));
    check("hold_hi", 64'(hi), 64'(prev_hi));
    @(negedge clk);
    a_i   = 32'd9;
    b_i   = 32'd9;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_ign", 64'(busy), 64'(1));
    wait_done();
    check_after();

    // start in the DONE cycle ignored, accepted on the following IDLE cycle
    start_op(32'd3, 32'd5);
    wait_done();
    a_i   = 32'hFFFF_FFFE;
    b_i   = 32'd7;
    start = 1'b1;
    sb.push_back(model(32'hFFFF_FFFE, 32'd7));
    @(posedge clk);
    #1;
    check("b2b_idle_busy", 64'(busy), 64'(0));
    check("b2b_idle_done", 64'(done), 64'(0));
    @(posedge clk);
    #1;
    start_cyc = cyc_cnt;
    start     = 1'b0;
    check("b2b_accept_busy", 64'(busy), 64'(1));
    wait_done();
    check_after();

    // Asynchronous reset mid-operation abandons the product
    start_op(32'd3, 32'd5);
    repeat (12) begin
      @(posedge clk);
      #1;
    end
    #2;
    reset = 1'b1;
    #1;
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_done", 64'(done), 64'(0));
    check("arst_hi", 64'(hi), 64'(0));
    check("arst_lo", 64'(lo), 64'(0));
    check("arst_ovf", 64'(overflow), 64'(0));
    sb.delete();
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("arst_hold_busy", 64'(busy), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) check("arst_no_done", 64'(done), 64'(0));
    end
    run(32'hFFFF_FFFD, 32'd5);

    repeat (2) @(posedge clk);
    check("sb_empty", 64'(sb.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
